alu_result_stage: RTL and testbench

Output stage of the 16-bit ALU, directly downstream of the bitwise logic gate array (OR/NOR/XOR/XNOR). It accepts each 16-bit gate result over a valid/ready handshake, optionally folds it into a running accumulator, and derives status flags. The word and its flags are buffered in a small FIFO, then presented to the consumer (register file write-back or test harness) over a second valid/ready handshake.

---
 rtl/alu_result_stage.sv | 115 +++++++++++
 tb/tb_alu_result_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU output stage: accumulate, flag and buffer gate-array results
module alu_result_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [1:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_zero,
  output logic                       out_neg,
  output logic                       out_parity,
  output logic [$clog2(WIDTH+1)-1:0] out_ones,
  output logic [WIDTH-1:0]           acc_value,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(WIDTH+1);
  localparam int CW = AW + 1;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_XOR  = 2'b01;
  localparam logic [1:0] MODE_OR   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] mem_data   [DEPTH];
  logic             mem_zero   [DEPTH];
  logic             mem_neg    [DEPTH];
  logic             mem_parity [DEPTH];
  logic [OW-1:0]    mem_ones   [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] acc;

  logic             full;
  logic             accept;
  logic             pop;
  logic [WIDTH-1:0] word;
  logic [OW-1:0]    word_ones;

  assign full      = (count_q == CW'(DEPTH));
  assign in_ready  = !full && !rst;
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    word = in_data;
    case (in_mode)
      MODE_XOR:  word = acc ^ in_data;
      MODE_OR:   word = acc | in_data;
      default:   word = in_data;
    endcase
  end

  always_comb begin
    word_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      word_ones = word_ones + OW'(word[i]);
    end
  end

  // Storage is cleared on reset so the head registers read back as all-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      acc     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i]   <= '0;
        mem_zero[i]   <= 1'b0;
        mem_neg[i]    <= 1'b0;
        mem_parity[i] <= 1'b0;
        mem_ones[i]   <= '0;
      end
    end else begin
      if (accept) begin
        mem_data[wr_ptr]   <= word;
        mem_zero[wr_ptr]   <= (word == '0);
        mem_neg[wr_ptr]    <= word[WIDTH-1];
        mem_parity[wr_ptr] <= ^word;
        mem_ones[wr_ptr]   <= word_ones;
        wr_ptr             <= wr_ptr + AW'(1);
        if (in_mode != MODE_PASS) begin
          acc <= word;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign out_data   = mem_data[rd_ptr];
  assign out_zero   = mem_zero[rd_ptr];
  assign out_neg    = mem_neg[rd_ptr];
  assign out_parity = mem_parity[rd_ptr];
  assign out_ones   = mem_ones[rd_ptr];
  assign acc_value  = acc;
  assign count      = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage with a queue-based reference model
module tb_alu_result_stage;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_zero;
  logic              out_neg;
  logic              out_parity;
  logic [4:0]        out_ones;
  logic [WIDTH-1:0]  acc_value;
  logic [2:0]        count;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] model_acc;

  alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_neg(out_neg), .out_parity(out_parity), .out_ones(out_ones),
    .acc_value(acc_value), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("count", 32'(count), 32'(model_q.size()));
    check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    check("acc_value", 32'(acc_value), 32'(model_acc));
    if (model_q.size() != 0) begin
      check("out_data", 32'(out_data), 32'(model_q[0]));
      check("out_zero", 32'(out_zero), 32'(model_q[0] == 0));
      check("out_neg", 32'(out_neg), 32'(model_q[0] >= 16'h8000));
      check("out_parity", 32'(out_parity), 32'($countones(model_q[0]) % 2));
      check("out_ones", 32'(out_ones), 32'($countones(model_q[0])));
    end
  endtask

  // One clock of stimulus; the model decides accept/pop from its own occupancy.
  task automatic cycle(input logic v, input logic [1:0] m, input logic [WIDTH-1:0] d, input logic r);
    logic [WIDTH-1:0] w;
    bit do_push, do_pop;
    in_valid = v; in_mode = m; in_data = d; out_ready = r;
    #1;
    check("in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
    do_push = v && (model_q.size() < DEPTH);
    do_pop  = r && (model_q.size() != 0);
    w = d;
    if (do_push) begin
      if (m == 2'd1) w = model_acc ^ d;
      if (m == 2'd2) w = model_acc | d;
      if (m != 2'd0) model_acc = w;
    end
    @(posedge clk);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back(w);
    #1;
    check_model();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 2'd0; out_ready = 1'b0;
    model_acc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    rst = 1'b0;
    check_model();

    // Pass mode and flags
    cycle(1'b1, 2'd0, 16'h8001, 1'b1);
    check("pass_data", 32'(out_data), 32'h8001);
    check("pass_neg", 32'(out_neg), 32'd1);
    check("pass_zero", 32'(out_zero), 32'd0);
    check("pass_parity", 32'(out_parity), 32'd0);
    check("pass_ones", 32'(out_ones), 32'd2);
    cycle(1'b1, 2'd0, 16'h0000, 1'b1);
    check("zero_zero", 32'(out_zero), 32'd1);
    check("zero_ones", 32'(out_ones), 32'd0);

    // Accumulate chain
    cycle(1'b1, 2'd3, 16'h00FF, 1'b1);
    check("chain_load", 32'(out_data), 32'h00FF);
    cycle(1'b1, 2'd1, 16'h0F0F, 1'b1);
    check("chain_xor", 32'(out_data), 32'h0FF0);
    cycle(1'b1, 2'd2, 16'h3000, 1'b1);
    check("chain_or", 32'(out_data), 32'h3FF0);
    check("chain_acc", 32'(acc_value), 32'h3FF0);
    cycle(1'b0, 2'd0, 16'h0, 1'b1);

    // Full / backpressure: word 5 held until a pop frees a slot
    for (int i = 1; i <= 5; i++) cycle(1'b1, 2'd0, 16'(i), 1'b0);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 2'd0, 16'd5, 1'b0);
    cycle(1'b1, 2'd0, 16'd5, 1'b1);
    check("full_pop_count", 32'(count), 32'd3);
    cycle(1'b1, 2'd0, 16'd5, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 2'd0, 16'h0, 1'b1);
    check("drain_count", 32'(count), 32'd0);

    // Simultaneous push/pop at count=2 across pointer wrap, random data and modes
    cycle(1'b1, 2'd0, 16'($urandom), 1'b0);
    cycle(1'b1, 2'd0, 16'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 1'b1);
      check("steady_count", 32'(count), 32'd2);
    end
    cycle(1'b0, 2'd0, 16'h0, 1'b1);
    cycle(1'b0, 2'd0, 16'h0, 1'b1);

    // Empty pop leaves state alone
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'($urandom_range(0, 3)), 16'($urandom), 1'b1);

    // Random traffic
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom), 2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom));

    // Reset mid-burst with 3 entries held
    while (model_q.size() != 0) cycle(1'b0, 2'd0, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'd2, 16'($urandom), 1'b0);
    check("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1; in_valid = 1'b1;
    #1;
    check("rst_hold_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_acc", 32'(acc_value), 32'd0);
    check("rst_in_ready2", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("rst_data2", 32'(out_data), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    model_q.delete();
    model_acc = '0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 10; i++)
      cycle(1'($urandom), 2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
